// File: rtl/serial_paralelo_if.sv
// Serial link bundle: one-bit line in, byte/strobe/lock out.
// master drives the line, slave is the receiver.
interface serial_paralelo_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output active
  );
endinterface

// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver for the 1-bit MSB-first PHY link.
// Aligns on comma bytes, locks, then strobes each non-comma byte.
module serial_paralelo #(
  parameter int          BC_COUNT = 4,
  parameter logic [7:0]  COMMA    = 8'hBC
) (
  input  logic         clk_32f,
  input  logic         reset,
  serial_paralelo_if.slave link
);

  localparam int BCW = $clog2(BC_COUNT + 1);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ALIGNING = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t         state;
  logic [6:0]     sr;
  logic [2:0]     bit_cnt;
  logic [BCW-1:0] bc_cnt;
  logic [7:0]     data_q;
  logic           valid_q;
  logic           active_q;

  logic [7:0] cand;
  logic       is_comma;
  logic       at_bound;

  // cand is the byte completed by the current edge
  assign cand     = {sr, link.data_in};
  assign is_comma = (cand == COMMA);
  assign at_bound = (bit_cnt == 3'd7);

  assign link.data_out  = data_q;
  assign link.valid_out = valid_q;
  assign link.active    = active_q;

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state    <= UNLOCKED;
      sr       <= '0;
      bit_cnt  <= '0;
      bc_cnt   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      sr      <= cand[6:0];
      valid_q <= 1'b0;
      unique case (state)
        UNLOCKED: begin
          bit_cnt <= '0;
          if (is_comma) begin
            bc_cnt <= BCW'(1);
            if (BC_COUNT == 1) begin
              state    <= LOCKED;
              active_q <= 1'b1;
            end else begin
              state <= ALIGNING;
            end
          end
        end
        ALIGNING: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (at_bound) begin
            if (is_comma) begin
              bc_cnt <= bc_cnt + 1'b1;
              if (bc_cnt == BCW'(BC_COUNT - 1)) begin
                state    <= LOCKED;
                active_q <= 1'b1;
              end
            end else begin
              // misaligned or broken comma run: restart the search
              state  <= UNLOCKED;
              bc_cnt <= '0;
            end
          end
        end
        LOCKED: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (at_bound && !is_comma) begin
            data_q  <= cand;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state <= UNLOCKED;
        end
      endcase
    end
  end

endmodule
